// File: rtl/card_display_bank.sv
// -----------------------------------------------------------------------------
// card_display_bank
//   Multi-channel registered card display driver for the baccarat datapath.
//
//   Each channel holds one dealt card code and drives one 7-segment digit.
//   - A newly loaded legal card (1..13) flashes for FLASH_TICKS tick strobes.
//     After that it shows steadily.
//   - Loading an illegal code (0, 14, 15) blanks the channel.
//   - A shared blink timebase toggles its phase every BLINK_TICKS ticks.
//     This timebase drives the flash display and the optional continuous
//     blink.
//
// Ports
//   slow_clock  : sole clock, rising edge
//   resetb      : asynchronous active-low reset
//   tick        : 1-cycle timebase strobe for blink/flash timing
//   clear       : synchronous clear of all channels (wins over load)
//   load        : per-channel load strobe, shared card_in
//   card_in     : card code (1=A .. 10, 11=J, 12=Q, 13=K)
//   blink_en    : per-channel continuous blink enable (SHOW only)
//   seg7_out    : channel i on [7i+6:7i], bit order gfedcba
//   valid       : channel holds a legal card
//   dealt_count : number of valid channels
// -----------------------------------------------------------------------------
module card_display_bank #(
    parameter int N_CHAN      = 6,
    parameter int BLINK_TICKS = 4,
    parameter int FLASH_TICKS = 16,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                        slow_clock,
    input  logic                        resetb,
    input  logic                        tick,
    input  logic                        clear,
    input  logic [N_CHAN-1:0]           load,
    input  logic [3:0]                  card_in,
    input  logic [N_CHAN-1:0]           blink_en,
    output logic [7*N_CHAN-1:0]         seg7_out,
    output logic [N_CHAN-1:0]           valid,
    output logic [$clog2(N_CHAN+1)-1:0] dealt_count
);

    localparam int CW = $clog2(N_CHAN + 1);
    localparam int FW = $clog2(FLASH_TICKS + 1);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    // Blank pattern in the output polarity.
    localparam logic [6:0] SEG_BLANK = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FLASH = 2'd1,
        ST_SHOW  = 2'd2
    } chan_state_t;

    // Active-low gfedcba decode; anything outside 1..13 is blank.
    function automatic logic [6:0] decode_card(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd1:    pat = 7'b0001000;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            4'd10:   pat = 7'b1000000;
            4'd11:   pat = 7'b1100001;
            4'd12:   pat = 7'b0011000;
            4'd13:   pat = 7'b0001001;
            default: pat = 7'b1111111;
        endcase
        return (ACTIVE_LOW != 0) ? pat : ~pat;
    endfunction

    // -------------------------------------------------------------------------
    // Shared blink timebase; clear deliberately leaves it running.
    // -------------------------------------------------------------------------
    logic [BW-1:0] blink_cnt_reg;
    logic          phase_on_reg;

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            blink_cnt_reg <= '0;
            phase_on_reg  <= 1'b1;
        end else if (tick) begin
            if (blink_cnt_reg == BW'(BLINK_TICKS - 1)) begin
                blink_cnt_reg <= '0;
                phase_on_reg  <= ~phase_on_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
        end
    end

    // Occupancy of each channel from the state registers.
    // It feeds the registered dealt_count.
    logic [N_CHAN-1:0] chan_busy;

    // -------------------------------------------------------------------------
    // Per-channel state machine and display register
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_CHAN; gi++) begin : g_chan
            chan_state_t state_reg;
            logic [3:0]  card_reg;
            logic [FW-1:0] flash_cnt_reg;
            logic [6:0]  seg_reg;
            logic        valid_reg;
            logic        card_legal;

            assign card_legal = (card_in >= 4'd1) && (card_in <= 4'd13);

            always_ff @(posedge slow_clock or negedge resetb) begin
                if (!resetb) begin
                    state_reg     <= ST_EMPTY;
                    card_reg      <= 4'd0;
                    flash_cnt_reg <= '0;
                end else if (clear) begin
                    state_reg     <= ST_EMPTY;
                    card_reg      <= 4'd0;
                    flash_cnt_reg <= '0;
                end else if (load[gi]) begin
                    // A load restarts the flash even if a tick arrives in the
                    // same cycle; the counter is reloaded, not decremented.
                    card_reg <= card_in;
                    if (card_legal) begin
                        state_reg     <= ST_FLASH;
                        flash_cnt_reg <= FW'(FLASH_TICKS);
                    end else begin
                        state_reg     <= ST_EMPTY;
                    end
                end else if (tick && (state_reg == ST_FLASH)) begin
                    if (flash_cnt_reg == FW'(1)) begin
                        state_reg <= ST_SHOW;
                    end
                    flash_cnt_reg <= flash_cnt_reg - 1'b1;
                end
            end

            // The display lags the state and card update by one cycle.
            always_ff @(posedge slow_clock or negedge resetb) begin
                if (!resetb) begin
                    seg_reg   <= SEG_BLANK;
                    valid_reg <= 1'b0;
                end else begin
                    valid_reg <= (state_reg != ST_EMPTY);
                    case (state_reg)
                        ST_FLASH: seg_reg <= phase_on_reg ? decode_card(card_reg) : SEG_BLANK;
                        ST_SHOW:  seg_reg <= (blink_en[gi] && !phase_on_reg) ? SEG_BLANK
                                                                             : decode_card(card_reg);
                        default:  seg_reg <= SEG_BLANK;
                    endcase
                end
            end

            assign chan_busy[gi]        = (state_reg != ST_EMPTY);
            assign seg7_out[7*gi +: 7]  = seg_reg;
            assign valid[gi]            = valid_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // dealt_count: popcount of the occupancy.
    // It is registered on the same edge as valid, so the two always agree.
    // -------------------------------------------------------------------------
    logic [CW-1:0] count_next;
    logic [CW-1:0] count_reg;

    always_comb begin
        count_next = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            count_next = count_next + CW'(chan_busy[i]);
        end
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign dealt_count = count_reg;

endmodule

// File: tb/tb_card_display_bank.sv
// -----------------------------------------------------------------------------
// tb_card_display_bank
//   Scoreboard bench for card_display_bank.
//
//   The driver applies stimulus on the falling edge.  It then pushes the
//   output expected after the next rising edge, computed by a reference model.
//   The model tracks the total tick count, remaining flash ticks per channel
//   and the card held.  The blink phase is derived from the total tick count.
//
//   A monitor pops one entry after each rising edge and compares it with the
//   DUT outputs.
// -----------------------------------------------------------------------------
module tb_card_display_bank;

    localparam int N    = 6;
    localparam int BT   = 4;
    localparam int FT   = 16;
    localparam int AL   = 1;
    localparam int CW   = $clog2(N + 1);

    localparam logic [6:0] PAT [0:15] = '{
        7'b1111111, 7'b0001000, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b1000000, 7'b1100001,
        7'b0011000, 7'b0001001, 7'b1111111, 7'b1111111
    };

    logic              slow_clock = 1'b0;
    logic              resetb     = 1'b0;
    logic              tick       = 1'b0;
    logic              clear      = 1'b0;
    logic [N-1:0]      load       = '0;
    logic [3:0]        card_in    = 4'd0;
    logic [N-1:0]      blink_en   = '0;
    logic [7*N-1:0]    seg7_out;
    logic [N-1:0]      valid;
    logic [CW-1:0]     dealt_count;

    card_display_bank #(
        .N_CHAN(N), .BLINK_TICKS(BT), .FLASH_TICKS(FT), .ACTIVE_LOW(AL)
    ) dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .tick       (tick),
        .clear      (clear),
        .load       (load),
        .card_in    (card_in),
        .blink_en   (blink_en),
        .seg7_out   (seg7_out),
        .valid      (valid),
        .dealt_count(dealt_count)
    );

    always #5 slow_clock = ~slow_clock;

    typedef struct {
        logic [7*N-1:0] seg;
        logic [N-1:0]   vld;
        logic [CW-1:0]  cnt;
    } exp_t;

    exp_t exp_q [$];

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    // Reference model.  Channel mode: 0 empty, 1 flashing, 2 showing.
    int m_mode  [N];
    int m_card  [N];
    int m_left  [N];
    int m_ticks;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [6:0] polar(input logic [6:0] p);
        return (AL != 0) ? p : ~p;
    endfunction

    function automatic bit model_phase_on();
        return ((m_ticks / BT) % 2) == 0;
    endfunction

    function automatic logic [6:0] model_digit(input int i, input logic be);
        logic [6:0] pat;
        pat = PAT[m_card[i]];
        if (m_mode[i] == 1 && model_phase_on())
            return polar(pat);
        if (m_mode[i] == 2 && !(be && !model_phase_on()))
            return polar(pat);
        return polar(7'b1111111);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mode[i] = 0;
            m_card[i] = 0;
            m_left[i] = 0;
        end
        m_ticks = 0;
    endtask

    // One clock of stimulus.  The expected output after the coming edge uses
    // the current model state (the previous edge's result) and blink_en now.
    task automatic step(input logic t, input logic c, input logic [N-1:0] ld,
                        input logic [3:0] ci, input logic [N-1:0] be);
        exp_t e;
        int   n;
        @(negedge slow_clock);
        tick = t; clear = c; load = ld; card_in = ci; blink_en = be;
        n = 0;
        for (int i = 0; i < N; i++) begin
            e.seg[7*i +: 7] = model_digit(i, be[i]);
            e.vld[i]        = (m_mode[i] != 0);
            if (m_mode[i] != 0) n++;
        end
        e.cnt = CW'(n);
        exp_q.push_back(e);
        // Advance the model across the coming edge.
        if (t) m_ticks++;
        for (int i = 0; i < N; i++) begin
            if (c) begin
                m_mode[i] = 0; m_card[i] = 0;
            end else if (ld[i]) begin
                m_card[i] = int'(ci);
                if (ci >= 1 && ci <= 13) begin
                    m_mode[i] = 1; m_left[i] = FT;
                end else begin
                    m_mode[i] = 0;
                end
            end else if (t && m_mode[i] == 1) begin
                m_left[i]--;
                if (m_left[i] == 0) m_mode[i] = 2;
            end
        end
    endtask

    // Monitor: the DUT presents a display word every cycle out of reset.
    always begin
        @(posedge slow_clock);
        #1;
        if (resetb && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            pops++;
            check("seg7_out", 64'(seg7_out), 64'(e.seg));
            check("valid", 64'(valid), 64'(e.vld));
            check("dealt_count", 64'(dealt_count), 64'(e.cnt));
        end
    end

    task automatic check_reset_outputs(input string tag);
        logic [7*N-1:0] blank_all;
        for (int i = 0; i < N; i++) blank_all[7*i +: 7] = polar(7'b1111111);
        check({tag, "_seg"}, 64'(seg7_out), 64'(blank_all));
        check({tag, "_valid"}, 64'(valid), 64'd0);
        check({tag, "_count"}, 64'(dealt_count), 64'd0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic async_reset();
        @(posedge slow_clock);
        #3;
        tick = 0; clear = 0; load = '0;
        resetb = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        exp_q.delete();
        @(negedge slow_clock);
        resetb = 1'b1;
    endtask

    initial begin
        logic [N-1:0] be;
        model_reset();
        #12;
        check_reset_outputs("por");
        @(negedge slow_clock);
        resetb = 1'b1;

        // Load K into channel 0, then let it flash out under steady ticks.
        step(0, 0, 6'b000001, 4'd13, '0);
        for (int k = 0; k < 24; k++) step(1, 0, '0, 4'd0, '0);

        // Illegal code into channel 2.
        step(0, 0, 6'b000100, 4'd14, '0);
        step(0, 0, '0, 4'd0, '0);

        // All channels at once, then clear overriding a load.
        step(0, 0, 6'b111111, 4'd10, '0);
        for (int k = 0; k < 20; k++) step(1, 0, '0, 4'd0, '0);
        step(0, 1, 6'b000010, 4'd5, '0);
        step(0, 0, '0, 4'd0, '0);

        // Channel 3 shows a 7 with continuous blink, ticking every cycle.
        step(0, 0, 6'b001000, 4'd7, 6'b001000);
        for (int k = 0; k < 40; k++) step(1, 0, '0, 4'd0, 6'b001000);

        // Reload during flash on a tick cycle, with 3 ticks left.
        step(0, 0, 6'b010000, 4'd9, '0);
        for (int k = 0; k < FT - 3; k++) step(1, 0, '0, 4'd0, '0);
        step(1, 0, 6'b010000, 4'd5, '0);
        for (int k = 0; k < FT + 4; k++) step(1, 0, '0, 4'd0, '0);

        // Reset while a card is flashing.
        step(0, 0, 6'b100000, 4'd1, '0);
        step(1, 0, '0, 4'd0, '0);
        step(0, 0, '0, 4'd0, '0);
        async_reset();

        // Randomised traffic, with a second reset partway through.
        be = '0;
        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] ld;
            for (int i = 0; i < N; i++) ld[i] = (($urandom % 12) == 0);
            if (($urandom % 30) == 0) be = N'($urandom);
            step(($urandom % 4) != 0, ($urandom % 80) == 0, ld, 4'($urandom % 16), be);
            if (k == 1500) async_reset();
        end
        step(0, 0, '0, 4'd0, be);

        repeat (3) @(posedge slow_clock);
        #2;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        if (pops < 3000) begin
            errors++;
            $display("FAIL monitor_pops actual=%0d required>=3000", pops);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
